// File: rtl/stream_pipe_buffer_if.sv
// Valid/ready stream bundle carrying one WIDTH-bit word per handshake.
interface stream_pipe_buffer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/stream_pipe_buffer.sv
// DEPTH-entry elastic buffer between two valid/ready streams, with synchronous
// flush and an occupancy count; all state updates on the rising edge of clk.
module stream_pipe_buffer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    stream_pipe_buffer_if.slave   ingress,
    stream_pipe_buffer_if.master  egress,
    output logic [CW-1:0]         count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths index only valid entries.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready/valid come from registered count only, so no out_ready->in_ready path.
    assign full          = (count == CW'(DEPTH));
    assign empty         = (count == '0);
    assign ingress.ready = ~full;
    assign egress.valid  = ~empty;
    assign egress.data   = mem[rd_ptr];

    assign push = ingress.valid & ~full;
    assign pop  = egress.ready & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= ingress.data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_pipe_buffer.sv
// Directed and scoreboarded checks of stream_pipe_buffer at WIDTH=8, DEPTH=4.
module tb_stream_pipe_buffer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    stream_pipe_buffer_if #(.WIDTH(WIDTH)) ingress ();
    stream_pipe_buffer_if #(.WIDTH(WIDTH)) egress ();

    stream_pipe_buffer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .ingress(ingress.slave),
        .egress (egress.master),
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 32'(egress.valid), 32'd0);
        check({tag, "_in_ready"},  32'(ingress.ready), 32'd1);
        check({tag, "_count"},     32'(count), 32'd0);
        check({tag, "_out_data"},  32'(egress.data), 32'h00);
    endtask

    logic [WIDTH-1:0] sb[$];
    int               pushed;
    int               popped;
    int               cycles;
    logic             m_push;
    logic             m_pop;
    logic [31:0]      rnd;

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        ingress.valid = 1'b0;
        ingress.data  = '0;
        egress.ready  = 1'b0;
        rnd = $urandom(32'd20240611);

        // Power-on reset then idle
        step();
        step();
        reset = 1'b0;
        step();
        check_idle("reset");

        // Single word, one-cycle latency
        egress.ready  = 1'b1;
        ingress.valid = 1'b1;
        ingress.data  = 8'h11;
        step();
        ingress.valid = 1'b0;
        check("single_valid", 32'(egress.valid), 32'd1);
        check("single_data",  32'(egress.data), 32'h11);
        check("single_count", 32'(count), 32'd1);
        step();
        check("single_drain_count", 32'(count), 32'd0);
        check("single_drain_valid", 32'(egress.valid), 32'd0);

        // Fill to full under backpressure; 0xA4 must be refused
        egress.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ingress.valid = 1'b1;
            ingress.data  = 8'(8'hA0 + i);
            check("fill_in_ready", 32'(ingress.ready), (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        ingress.valid = 1'b0;
        check("full_count",    32'(count), 32'd4);
        check("full_in_ready", 32'(ingress.ready), 32'd0);
        egress.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(egress.valid), 32'd1);
            check("drain_data",  32'(egress.data), 32'h0A0 + 32'(i));
            step();
            if (i == 0) check("full_pop_in_ready", 32'(ingress.ready), 32'd1);
        end
        check("drain_empty_count", 32'(count), 32'd0);

        // Streaming at full rate across two pointer wraps
        for (int i = 0; i < 10; i++) begin
            ingress.valid = 1'b1;
            ingress.data  = 8'(i);
            step();
            check("stream_data",  32'(egress.data), 32'(i));
            check("stream_count", 32'(count), 32'd1);
        end
        ingress.valid = 1'b0;
        step();
        check("stream_end_count", 32'(count), 32'd0);

        // Flush with a coincident push that must be discarded
        egress.ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            ingress.valid = 1'b1;
            ingress.data  = 8'(i);
            step();
        end
        check("preflush_count", 32'(count), 32'd3);
        flush         = 1'b1;
        ingress.data  = 8'h55;
        step();
        flush         = 1'b0;
        ingress.valid = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(egress.valid), 32'd0);
        ingress.valid = 1'b1;
        ingress.data  = 8'h66;
        egress.ready  = 1'b1;
        step();
        ingress.valid = 1'b0;
        check("postflush_data",  32'(egress.data), 32'h66);
        check("postflush_count", 32'(count), 32'd1);
        step();
        check("postflush_drain", 32'(count), 32'd0);

        // Random traffic against a scoreboard queue
        pushed = 0;
        popped = 0;
        cycles = 0;
        while (popped < 1000 && cycles < 20000) begin
            ingress.valid = ($urandom_range(0, 1) == 1) && (pushed < 1000);
            ingress.data  = 8'($urandom);
            egress.ready  = ($urandom_range(0, 2) != 0);
            #1;
            check("rand_in_ready",  32'(ingress.ready), (sb.size() != DEPTH) ? 32'd1 : 32'd0);
            check("rand_out_valid", 32'(egress.valid), (sb.size() != 0) ? 32'd1 : 32'd0);
            check("rand_count",     32'(count), 32'(sb.size()));
            m_push = ingress.valid && (sb.size() != DEPTH);
            m_pop  = egress.ready && (sb.size() != 0);
            if (m_pop) begin
                check("rand_data", 32'(egress.data), 32'(sb[0]));
                void'(sb.pop_front());
                popped++;
            end
            if (m_push) begin
                sb.push_back(ingress.data);
                pushed++;
            end
            step();
            cycles++;
        end
        check("rand_done", 32'(popped), 32'd1000);
        ingress.valid = 1'b0;
        egress.ready  = 1'b0;
        step();

        // Reset mid-burst must match power-on state
        for (int i = 0; i < 2; i++) begin
            ingress.valid = 1'b1;
            ingress.data  = 8'(8'hC0 + i);
            step();
        end
        ingress.valid = 1'b0;
        check("preburst_count", 32'(count), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
